// File: rtl/resize_out_fifo.sv
// resize_out_fifo: elastic output buffer behind the frame resize block.
// The upstream stream cannot stall. This block buffers the beats and offers a
// first-word-fall-through AXI-stream master to the downstream consumer.
// When the buffer overflows, the rest of that frame is dropped. The block then
// starts accepting again at the next start-of-frame (tuser) beat.
//
// Handshake: a beat moves from master to consumer on every rising clkNx edge
// where m_axis_tvalid and m_axis_tready are both high. While tvalid is high
// and tready is low, the head fields hold steady. The slave side has no ready
// signal: a beat is taken on every edge where s_axis_tvalid is high, and the
// FSM decides whether to store it or drop it.
module resize_out_fifo #(
    parameter int DATA_W     = 24,
    parameter int DEPTH_LOG2 = 10,
    parameter int AFULL_LVL  = 1000
) (
    input  logic                  clkNx,
    input  logic                  rst,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  afull,
    input  logic                  clr_status,
    output logic                  overflow_sticky,
    output logic [15:0]           frames_dropped,
    output logic [1:0]            dbg_state_o
);

    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam int                  ENTRY_W = DATA_W + 2;
    localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AFULL_L = (DEPTH_LOG2+1)'(AFULL_LVL);

    // Frame-sync FSM states
    localparam logic [1:0] ST_WAIT_SOF = 2'd0;
    localparam logic [1:0] ST_PASS     = 2'd1;
    localparam logic [1:0] ST_DROP     = 2'd2;

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  afull_q;
    logic [1:0]            state_q, state_d;
    logic                  sticky_q, sticky_d;
    logic [15:0]           dropped_q, dropped_d;
    logic                  full, wr_en, rd_en, drop_evt;
    logic [ENTRY_W-1:0]    head;

    // full is taken from the registered level, so a read in the same cycle
    // does not free a slot for a write.
    assign full  = (level_q == DEPTH_L);
    assign rd_en = m_axis_tvalid & m_axis_tready;

    // Accept/drop decision and frame-sync state transitions
    always_comb begin
        wr_en    = 1'b0;
        drop_evt = 1'b0;
        state_d  = state_q;
        case (state_q)
            ST_WAIT_SOF: begin
                if (s_axis_tvalid && s_axis_tuser && !full) begin
                    wr_en   = 1'b1;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                if (s_axis_tvalid) begin
                    if (!full) begin
                        wr_en = 1'b1;
                    end else begin
                        drop_evt = 1'b1;
                        state_d  = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (s_axis_tvalid && s_axis_tuser) begin
                    if (!full) begin
                        wr_en   = 1'b1;
                        state_d = ST_PASS;
                    end else begin
                        drop_evt = 1'b1;
                    end
                end
            end
            default: state_d = ST_WAIT_SOF;
        endcase
    end

    // Fill-level next state: write and read in the same cycle cancel out
    always_comb begin
        level_d = level_q;
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Status next state: an overflow event in the same cycle as a clear wins
    always_comb begin
        sticky_d  = clr_status ? 1'b0  : sticky_q;
        dropped_d = clr_status ? 16'h0 : dropped_q;
        if (drop_evt) begin
            sticky_d = 1'b1;
            if (dropped_d != 16'hFFFF) begin
                dropped_d = dropped_d + 16'd1;
            end
        end
    end

    // Buffer storage; the contents need no reset because level gates the output
    always_ff @(posedge clkNx) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
        end
    end

    // Pointers, level, afull, FSM and status registers
    always_ff @(posedge clkNx) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            afull_q   <= 1'b0;
            state_q   <= ST_WAIT_SOF;
            sticky_q  <= 1'b0;
            dropped_q <= 16'h0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q   <= level_d;
            afull_q   <= (level_d >= AFULL_L);
            state_q   <= state_d;
            sticky_q  <= sticky_d;
            dropped_q <= dropped_d;
        end
    end

    // First-word-fall-through head; fields are forced to 0 while the buffer is empty
    assign head          = mem[rd_ptr_q];
    assign m_axis_tvalid = (level_q != '0);
    assign m_axis_tuser  = m_axis_tvalid & head[ENTRY_W-1];
    assign m_axis_tlast  = m_axis_tvalid & head[ENTRY_W-2];
    assign m_axis_tdata  = m_axis_tvalid ? head[DATA_W-1:0] : '0;

    assign level           = level_q;
    assign afull           = afull_q;
    assign overflow_sticky = sticky_q;
    assign frames_dropped  = dropped_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_resize_out_fifo.sv
// Directed bench for resize_out_fifo with a 16-entry buffer and afull level 12.
module tb_resize_out_fifo;

    localparam int DW = 24;
    localparam int DL = 4;

    logic          clkNx = 1'b0;
    logic          rst = 1'b1;
    logic          s_axis_tvalid = 1'b0, s_axis_tuser = 1'b0, s_axis_tlast = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [DL:0]   level;
    logic          afull;
    logic          clr_status = 1'b0;
    logic          overflow_sticky;
    logic [15:0]   frames_dropped;
    logic [1:0]    dbg_state_o;

    int checks = 0;
    int failures = 0;

    resize_out_fifo #(.DATA_W(DW), .DEPTH_LOG2(DL), .AFULL_LVL(12)) dut (
        .clkNx(clkNx), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
        .m_axis_tready(m_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
        .level(level), .afull(afull), .clr_status(clr_status),
        .overflow_sticky(overflow_sticky), .frames_dropped(frames_dropped),
        .dbg_state_o(dbg_state_o)
    );

    // clock
    always #5 clkNx = ~clkNx;

    // one clock, then settle 1 time unit past the edge
    task automatic tick();
        @(posedge clkNx);
        #1;
    endtask

    task automatic beat(input logic v, input logic u, input logic l, input logic [DW-1:0] d);
        s_axis_tvalid = v;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tdata  = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        chk({tag, "_tuser"}, 32'(m_axis_tuser), 32'd0);
        chk({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
        chk({tag, "_tdata"}, 32'(m_axis_tdata), 32'd0);
        chk({tag, "_afull"}, 32'(afull), 32'd0);
    endtask

    initial begin
        // ---- reset
        tick(); tick();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset_sticky", 32'(overflow_sticky), 32'd0);
        chk("reset_dropped", 32'(frames_dropped), 32'd0);
        chk("reset_state", 32'(dbg_state_o), 32'd0);

        // ---- post-reset sync: non-tuser beats are ignored
        m_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, 1'b0, 1'b0, DW'(i + 1));
            tick();
            chk("sync_level", 32'(level), 32'd0);
            chk("sync_tvalid", 32'(m_axis_tvalid), 32'd0);
        end
        beat(1'b1, 1'b1, 1'b0, 24'hAA);
        tick();
        beat(1'b0, 1'b0, 1'b0, '0);
        chk("sof_level", 32'(level), 32'd1);
        chk("sof_tuser", 32'(m_axis_tuser), 32'd1);
        chk("sof_tdata", 32'(m_axis_tdata), 32'hAA);
        chk("sof_state", 32'(dbg_state_o), 32'd1);
        tick();
        chk("sof_drain_level", 32'(level), 32'd0);

        // ---- pass-through with tready=1
        for (int i = 0; i < 16; i++) begin
            beat(1'b1, i == 0, (i % 4) == 3, DW'(i));
            tick();
            chk("pt_tvalid", 32'(m_axis_tvalid), 32'd1);
            chk("pt_tdata", 32'(m_axis_tdata), 32'(i));
            chk("pt_tuser", 32'(m_axis_tuser), 32'(i == 0));
            chk("pt_tlast", 32'(m_axis_tlast), 32'((i % 4) == 3));
            chk("pt_level", 32'(level), 32'd1);
        end
        beat(1'b0, 1'b0, 1'b0, '0);
        tick();
        chk_idle("pt_end");
        chk("pt_sticky", 32'(overflow_sticky), 32'd0);
        chk("pt_dropped", 32'(frames_dropped), 32'd0);

        // ---- backpressure: fill to 16, then drain in order
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            beat(1'b1, i == 0, (i % 4) == 3, DW'(i));
            tick();
            chk("bp_level", 32'(level), 32'(i + 1));
            chk("bp_afull", 32'(afull), 32'((i + 1) >= 12));
            chk("bp_head", 32'(m_axis_tdata), 32'd0);
        end
        beat(1'b0, 1'b0, 1'b0, '0);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("bp_out_tdata", 32'(m_axis_tdata), 32'(i));
            chk("bp_out_tuser", 32'(m_axis_tuser), 32'(i == 0));
            chk("bp_out_tlast", 32'(m_axis_tlast), 32'((i % 4) == 3));
            tick();
            chk("bp_out_level", 32'(level), 32'(15 - i));
            chk("bp_out_afull", 32'(afull), 32'((15 - i) >= 12));
        end
        chk_idle("bp_end");

        // ---- overflow: 20-beat frame into a stalled 16-entry buffer
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            beat(1'b1, i == 0, 1'b0, DW'(32'h100 + i));
            tick();
            chk("ov_level", 32'(level), 32'(i < 16 ? i + 1 : 16));
            chk("ov_sticky", 32'(overflow_sticky), 32'(i >= 16));
            chk("ov_dropped", 32'(frames_dropped), 32'(i >= 16));
        end
        chk("ov_state", 32'(dbg_state_o), 32'd2);
        beat(1'b0, 1'b0, 1'b0, '0);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("ov_out_tdata", 32'(m_axis_tdata), 32'h100 + 32'(i));
            tick();
        end
        chk_idle("ov_drained");
        // beats without tuser while in DROP stay discarded
        beat(1'b1, 1'b0, 1'b0, 24'h1FF);
        tick();
        chk("ov_drop_level", 32'(level), 32'd0);
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, i == 0, i == 3, DW'(32'h200 + i));
            tick();
            chk("ov_next_tdata", 32'(m_axis_tdata), 32'h200 + 32'(i));
            chk("ov_next_tuser", 32'(m_axis_tuser), 32'(i == 0));
            chk("ov_next_tlast", 32'(m_axis_tlast), 32'(i == 3));
        end
        chk("ov_next_state", 32'(dbg_state_o), 32'd1);
        beat(1'b0, 1'b0, 1'b0, '0);
        tick();
        chk("ov_next_level", 32'(level), 32'd0);

        // ---- clear status on its own
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("clr_sticky", 32'(overflow_sticky), 32'd0);
        chk("clr_dropped", 32'(frames_dropped), 32'd0);

        // ---- full with simultaneous read and write
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            beat(1'b1, i == 0, 1'b0, DW'(32'h300 + i));
            tick();
        end
        chk("frw_level_full", 32'(level), 32'd16);
        chk("frw_state_pass", 32'(dbg_state_o), 32'd1);
        m_axis_tready = 1'b1;
        beat(1'b1, 1'b0, 1'b0, 24'h3FF);
        tick();
        beat(1'b0, 1'b0, 1'b0, '0);
        chk("frw_level", 32'(level), 32'd15);
        chk("frw_state", 32'(dbg_state_o), 32'd2);
        chk("frw_dropped", 32'(frames_dropped), 32'd1);
        chk("frw_sticky", 32'(overflow_sticky), 32'd1);
        chk("frw_head", 32'(m_axis_tdata), 32'h301);
        for (int i = 0; i < 15; i++) tick();
        chk("frw_drained", 32'(level), 32'd0);

        // ---- reset mid-operation with level 10
        m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, i == 0, 1'b0, DW'(32'h400 + i));
            tick();
        end
        beat(1'b0, 1'b0, 1'b0, '0);
        chk("rst_pre_level", 32'(level), 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rst_mid");
        chk("rst_mid_sticky", 32'(overflow_sticky), 32'd0);
        chk("rst_mid_dropped", 32'(frames_dropped), 32'd0);
        chk("rst_mid_state", 32'(dbg_state_o), 32'd0);
        tick();
        chk("rst_mid_after", 32'(m_axis_tvalid), 32'd0);

        // ---- overflow events: PASS->DROP, then a tuser beat while still full
        for (int i = 0; i < 16; i++) begin
            beat(1'b1, i == 0, 1'b0, DW'(32'h500 + i));
            tick();
        end
        beat(1'b1, 1'b0, 1'b0, 24'h5AA);
        tick();
        chk("ev1_dropped", 32'(frames_dropped), 32'd1);
        beat(1'b1, 1'b1, 1'b0, 24'h5BB);
        tick();
        chk("ev2_dropped", 32'(frames_dropped), 32'd2);
        chk("ev2_state", 32'(dbg_state_o), 32'd2);
        chk("ev2_level", 32'(level), 32'd16);
        // clear in the same cycle as another overflow event: the event wins
        clr_status = 1'b1;
        beat(1'b1, 1'b1, 1'b0, 24'h5CC);
        tick();
        clr_status = 1'b0;
        beat(1'b0, 1'b0, 1'b0, '0);
        chk("clrev_sticky", 32'(overflow_sticky), 32'd1);
        chk("clrev_dropped", 32'(frames_dropped), 32'd1);
        chk("clrev_head", 32'(m_axis_tdata), 32'h500);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("clr2_sticky", 32'(overflow_sticky), 32'd0);
        chk("clr2_dropped", 32'(frames_dropped), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // run-time bound
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
